// File: rtl/tcm_arbiter.sv
// tcm_arbiter: two-port arbiter in front of a single-ported TCM.
//   Port 0 (core LSU) has fixed priority over port 1 (DMA/debug).
//   Grants are combinational. Each granted access gets an rvalid pulse
//   exactly one cycle later, for reads and for writes.
//   Optional feature macro: TCM_ARB_STARVE_EN. When it is defined, a wait
//   counter forces port 1 to win after STARVE_LIMIT consecutive lost cycles.
//   When it is undefined, arbitration is strict port-0 priority.
// Handshake: a requester holds pN_req_i and its attributes until it sees
//   pN_gnt_o high in the same cycle. An access is accepted in a cycle where
//   req && gnt. Its response is pN_rvalid_o, exactly one cycle later.
//   Requests that are not granted are never stored.
// Debug: dbg_starve_cnt_o exposes the starvation counter. It is 0 when the
//   feature is not built.
module tcm_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // port 0: core LSU
    input  logic                    p0_req_i,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    // port 1: DMA / debug
    input  logic                    p1_req_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    // TCM side
    output logic                    tcm_en_o,
    output logic [ADDR_WIDTH-1:0]   tcm_addr_o,
    output logic                    tcm_we_o,
    output logic [DATA_WIDTH/8-1:0] tcm_be_o,
    output logic [DATA_WIDTH-1:0]   tcm_wdata_o,
    input  logic [DATA_WIDTH-1:0]   tcm_rdata_i,
    // debug
    output logic [7:0]              dbg_starve_cnt_o
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic       starve;      // port 1 has waited long enough to override port 0
    logic [7:0] starve_cnt;
    logic       resp_valid;  // an access was granted last cycle
    logic       resp_id;     // winner of last cycle: 0 = port 0, 1 = port 1

`ifdef TCM_ARB_STARVE_EN
    assign starve = p1_req_i && (starve_cnt == STARVE_MAX);

    // Count consecutive cycles in which port 1 requests but loses.
    // The count saturates at the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= 8'd0;
        end else if (!p1_req_i || p1_gnt_o) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign starve            = 1'b0;
    assign starve_cnt        = 8'd0;
`endif

    assign dbg_starve_cnt_o = starve_cnt;

    // Combinational winner selection. No grants are issued during reset.
    always_comb begin
        p0_gnt_o = 1'b0;
        p1_gnt_o = 1'b0;
        if (!rst_i) begin
            if (p1_req_i && (starve || !p0_req_i)) begin
                p1_gnt_o = 1'b1;
            end else if (p0_req_i) begin
                p0_gnt_o = 1'b1;
            end
        end
    end

    // Route the winner's access to the TCM. All fields are zero when idle.
    always_comb begin
        tcm_en_o    = p0_gnt_o | p1_gnt_o;
        tcm_addr_o  = '0;
        tcm_we_o    = 1'b0;
        tcm_be_o    = '0;
        tcm_wdata_o = '0;
        if (p1_gnt_o) begin
            tcm_addr_o  = p1_addr_i;
            tcm_we_o    = p1_we_i;
            tcm_be_o    = p1_be_i;
            tcm_wdata_o = p1_wdata_i;
        end else if (p0_gnt_o) begin
            tcm_addr_o  = p0_addr_i;
            tcm_we_o    = p0_we_i;
            tcm_be_o    = p0_be_i;
            tcm_wdata_o = p0_wdata_i;
        end
    end

    // Remember who was granted, so the response goes to the right port next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
        end else begin
            resp_valid <= p0_gnt_o | p1_gnt_o;
            resp_id    <= p1_gnt_o;
        end
    end

    assign p0_rvalid_o = resp_valid && !resp_id;
    assign p1_rvalid_o = resp_valid &&  resp_id;
    assign p0_rdata_o  = tcm_rdata_i;
    assign p1_rdata_o  = tcm_rdata_i;

endmodule
